// File: rtl/clock_display.sv
// ---------------------------------------------------------------------------
// clock_display
//
// Multiplexed four-digit seven-segment driver for a two-player chess clock.
// It also latches the game result when either player's timer expires.
//
// Digit layout, from the rightmost digit (index 0) to the leftmost (index 3):
//     Black time | dash | dash | White time
// The decimal point marks the side to move while the game runs. After a
// result is latched, the digit of each side that ran out of time blinks.
//
// Parameters
//   REFRESH_DIV  clk_one cycles each digit is lit (>= 2)
//   BLINK_DIV    clk_one cycles per blink half-period (>= 2)
//
// Ports
//   clk_one  in   sole clock, rising edge
//   reset    in   synchronous, active-high
//   start    in   game running flag
//   player   in   side to move: 0 = White (time1), 1 = Black (time2)
//   time1    in   White remaining time, 0..7
//   time2    in   Black remaining time, 0..7
//   zero1    in   White timer expired
//   zero2    in   Black timer expired
//   an       out  digit enables, active-low, one digit low at a time
//   seg      out  segments a..g on seg[0]..seg[6], active-low
//   dp       out  decimal point, active-low
//   winner   out  00 none, 01 White wins, 10 Black wins, 11 draw
// ---------------------------------------------------------------------------
module clock_display #(
    parameter int REFRESH_DIV = 1000,
    parameter int BLINK_DIV   = 250000
) (
    input  logic       clk_one,
    input  logic       reset,
    input  logic       start,
    input  logic       player,
    input  logic [2:0] time1,
    input  logic [2:0] time2,
    input  logic       zero1,
    input  logic       zero2,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] winner
);

    // -----------------------------------------------------------------------
    // Counter widths and terminal counts
    // -----------------------------------------------------------------------
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);

    // Winner states. The encoding is the winner output value.
    localparam logic [1:0] ST_NONE  = 2'b00;
    localparam logic [1:0] ST_WHITE = 2'b01;
    localparam logic [1:0] ST_BLACK = 2'b10;
    localparam logic [1:0] ST_DRAW  = 2'b11;

    // Active-low segment patterns, seg[6:0] = g..a
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit enables, active-low
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;
    localparam logic [3:0] AN_OFF = 4'b1111;

    // -----------------------------------------------------------------------
    // Seven-segment encoder for the digits 0..7
    // -----------------------------------------------------------------------
    function automatic logic [6:0] seg_encode(input logic [2:0] value);
        logic [6:0] pattern;
        case (value)
            3'd0:    pattern = 7'b1000000;
            3'd1:    pattern = 7'b1111001;
            3'd2:    pattern = 7'b0100100;
            3'd3:    pattern = 7'b0110000;
            3'd4:    pattern = 7'b0011001;
            3'd5:    pattern = 7'b0010010;
            3'd6:    pattern = 7'b0000010;
            3'd7:    pattern = 7'b1111000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // -----------------------------------------------------------------------
    // Input registers
    // -----------------------------------------------------------------------
    logic       start_q;
    logic       player_q;
    logic [2:0] time1_q;
    logic [2:0] time2_q;
    logic       zero1_q;
    logic       zero2_q;

    always_ff @(posedge clk_one) begin
        if (reset) begin
            start_q  <= 1'b0;
            player_q <= 1'b0;
            time1_q  <= '0;
            time2_q  <= '0;
            zero1_q  <= 1'b0;
            zero2_q  <= 1'b0;
        end else begin
            start_q  <= start;
            player_q <= player;
            time1_q  <= time1;
            time2_q  <= time2;
            zero1_q  <= zero1;
            zero2_q  <= zero2;
        end
    end

    // -----------------------------------------------------------------------
    // Refresh counter and digit index
    // -----------------------------------------------------------------------
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]    digit_q,   digit_d;

    always_comb begin
        ref_cnt_d = ref_cnt_q + RW'(1);
        digit_d   = digit_q;
        if (ref_cnt_q == REF_LAST) begin
            ref_cnt_d = '0;
            digit_d   = digit_q + 2'd1;
        end
    end

    always_ff @(posedge clk_one) begin
        if (reset) begin
            ref_cnt_q <= '0;
            digit_q   <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            digit_q   <= digit_d;
        end
    end

    // -----------------------------------------------------------------------
    // Winner FSM. Every result state is absorbing until reset.
    // -----------------------------------------------------------------------
    logic [1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (state_q == ST_NONE) begin
            case ({zero1_q, zero2_q})
                2'b11:   state_d = ST_DRAW;
                2'b10:   state_d = ST_BLACK;
                2'b01:   state_d = ST_WHITE;
                default: state_d = ST_NONE;
            endcase
        end
    end

    always_ff @(posedge clk_one) begin
        if (reset) begin
            state_q <= ST_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Blink timer. It is frozen at zero until a result exists, so the first
    // blank half-period starts a full BLINK_DIV after the result latches.
    // -----------------------------------------------------------------------
    logic [BW-1:0] blk_cnt_q, blk_cnt_d;
    logic          blink_q,   blink_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        blink_d   = blink_q;
        if (state_q == ST_NONE) begin
            blk_cnt_d = '0;
            blink_d   = 1'b0;
        end else if (blk_cnt_q == BLK_LAST) begin
            blk_cnt_d = '0;
            blink_d   = ~blink_q;
        end else begin
            blk_cnt_d = blk_cnt_q + BW'(1);
        end
    end

    always_ff @(posedge clk_one) begin
        if (reset) begin
            blk_cnt_q <= '0;
            blink_q   <= 1'b0;
        end else begin
            blk_cnt_q <= blk_cnt_d;
            blink_q   <= blink_d;
        end
    end

    // -----------------------------------------------------------------------
    // Display decode (registered)
    // -----------------------------------------------------------------------
    logic       blank1;   // hide White's digit during the blink-off phase
    logic       blank2;   // hide Black's digit during the blink-off phase
    logic       running;  // side-to-move marker enabled
    logic [3:0] an_q,  an_d;
    logic [6:0] seg_q, seg_d;
    logic       dp_q,  dp_d;

    always_comb begin
        blank1  = blink_q && ((state_q == ST_BLACK) || (state_q == ST_DRAW));
        blank2  = blink_q && ((state_q == ST_WHITE) || (state_q == ST_DRAW));
        running = start_q && (state_q == ST_NONE);

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;

        case (digit_q)
            2'd0: begin
                an_d  = AN_D0;
                seg_d = blank2 ? SEG_BLANK : seg_encode(time2_q);
                if (running && player_q) begin
                    dp_d = 1'b0;
                end
            end
            2'd1: begin
                an_d  = AN_D1;
                seg_d = SEG_DASH;
            end
            2'd2: begin
                an_d  = AN_D2;
                seg_d = SEG_DASH;
            end
            default: begin
                an_d  = AN_D3;
                seg_d = blank1 ? SEG_BLANK : seg_encode(time1_q);
                if (running && !player_q) begin
                    dp_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk_one) begin
        if (reset) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign an     = an_q;
    assign seg    = seg_q;
    assign dp     = dp_q;
    assign winner = state_q;

endmodule
